cordic: RTL and testbench

CORDIC -- requirements
Module: cordic

---
 rtl/cordic_pkg.sv | 82 ++++++++
 rtl/cordic_stage.sv | 39 +++
 rtl/cordic.sv | 124 ++++++++++++
 tb/tb_cordic.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module : cordic_pkg
// Shared widths, CORDIC constants, atan table, FSM states and float->Q10.22
// conversion. Optional macro: CORDIC_CLAMP_EN (clamp angles above 1.0 to 1.0).
// Rev    : 1.0
// ============================================================================
package cordic_pkg;

  localparam int DATA_W      = 32;
  localparam int FRAC_W      = 22;
  localparam int N_ITER      = 20;
  localparam int ROT_PER_CYC = 5;
  localparam int ITER_CYC    = N_ITER / ROT_PER_CYC;

  localparam logic signed [DATA_W-1:0] K_INIT = 32'sh0026DD3B;
  localparam logic signed [DATA_W-1:0] ONE_Q  = 32'sh00400000;

  // Float exponent at which the 24-bit significand lands unshifted in Q10.22.
  localparam int EXP_PIVOT = 127 + 23 - FRAC_W;
  localparam int EXP_MIN   = 105;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // atan(2^-i) in Q10.22, rounded to nearest.
  function automatic logic signed [DATA_W-1:0] atan_q(input logic [4:0] idx);
    logic signed [DATA_W-1:0] v;
    case (idx)
      5'd0:    v = 32'sh003243F7;
      5'd1:    v = 32'sh001DAC67;
      5'd2:    v = 32'sh000FADBB;
      5'd3:    v = 32'sh0007F56F;
      5'd4:    v = 32'sh0003FEAB;
      5'd5:    v = 32'sh0001FFD5;
      5'd6:    v = 32'sh0000FFFB;
      5'd7:    v = 32'sh00007FFF;
      5'd8:    v = 32'sh00004000;
      5'd9:    v = 32'sh00002000;
      5'd10:   v = 32'sh00001000;
      5'd11:   v = 32'sh00000800;
      5'd12:   v = 32'sh00000400;
      5'd13:   v = 32'sh00000200;
      5'd14:   v = 32'sh00000100;
      5'd15:   v = 32'sh00000080;
      5'd16:   v = 32'sh00000040;
      5'd17:   v = 32'sh00000020;
      5'd18:   v = 32'sh00000010;
      5'd19:   v = 32'sh00000008;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Magnitude of an IEEE-754 single (sign already dropped) as truncated Q10.22.
  function automatic logic signed [DATA_W-1:0] f2q(input logic [30:0] f);
    logic [7:0]        e;
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] q;
    e = f[30:23];
    m = {8'd0, 1'b1, f[22:0]};
    if (e < 8'(EXP_MIN)) begin
      q = '0;
    end else if (e >= 8'(EXP_PIVOT)) begin
      q = m << (e - 8'(EXP_PIVOT));
    end else begin
      q = m >> (8'(EXP_PIVOT) - e);
    end
`ifdef CORDIC_CLAMP_EN
    if ((e >= 8'(EXP_PIVOT)) || (q > ONE_Q)) begin
      q = ONE_Q;
    end
`endif
    return signed'(q);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_stage.sv
`default_nettype none
// ============================================================================
// Module : cordic_stage
// One combinational rotation-mode micro-rotation; shift = i_base + IDX.
// Rev    : 1.0
// ============================================================================
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [4:0]               i_base,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_y,
  input  logic signed [DATA_W-1:0] i_z,
  output logic signed [DATA_W-1:0] o_x,
  output logic signed [DATA_W-1:0] o_y,
  output logic signed [DATA_W-1:0] o_z
);

  logic [4:0]               w_shift;
  logic signed [DATA_W-1:0] w_xs;
  logic signed [DATA_W-1:0] w_ys;
  logic signed [DATA_W-1:0] w_atan;
  logic                     w_pos;

  assign w_shift = i_base + 5'(IDX);
  assign w_xs    = i_x >>> w_shift;
  assign w_ys    = i_y >>> w_shift;
  assign w_atan  = atan_q(w_shift);
  // z == 0 rotates in the positive direction.
  assign w_pos   = ~i_z[DATA_W-1];

  assign o_x = w_pos ? (i_x - w_ys)   : (i_x + w_ys);
  assign o_y = w_pos ? (i_y + w_xs)   : (i_y - w_xs);
  assign o_z = w_pos ? (i_z - w_atan) : (i_z + w_atan);

endmodule
`default_nettype wire

// File: rtl/cordic.sv
`default_nettype none
// ============================================================================
// Module : cordic
// cos(|dataa|) for a float angle via 20-step CORDIC, 5 rotations per cycle.
// Optional macro: CORDIC_CLAMP_EN.   Rev : 1.0
// ============================================================================
module cordic
  import cordic_pkg::*;
(
  input  logic              clock,
  input  logic              aclr,
  input  logic              clk_en,
  input  logic              start,
  input  logic [DATA_W-1:0] dataa,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  state_e                   state_q,  state_d;
  logic [1:0]               cnt_q,    cnt_d;
  logic [30:0]              dataa_q,  dataa_d;
  logic signed [DATA_W-1:0] x_q,      x_d;
  logic signed [DATA_W-1:0] y_q,      y_d;
  logic signed [DATA_W-1:0] z_q,      z_d;
  logic signed [DATA_W-1:0] result_q, result_d;
  logic                     done_q,   done_d;

  logic [4:0]               w_base;
  logic signed [DATA_W-1:0] w_x [ROT_PER_CYC+1];
  logic signed [DATA_W-1:0] w_y [ROT_PER_CYC+1];
  logic signed [DATA_W-1:0] w_z [ROT_PER_CYC+1];
  logic                     w_unused_sign;

  // Cosine is even, so the float sign bit never enters the datapath.
  assign w_unused_sign = dataa[DATA_W-1];

  assign w_base = {1'b0, cnt_q, 2'b00} + {3'b000, cnt_q};
  assign w_x[0] = x_q;
  assign w_y[0] = y_q;
  assign w_z[0] = z_q;

  generate
    for (genvar k = 0; k < ROT_PER_CYC; k++) begin : g_stage
      cordic_stage #(.IDX(k)) u_stage (
        .i_base (w_base),
        .i_x    (w_x[k]),
        .i_y    (w_y[k]),
        .i_z    (w_z[k]),
        .o_x    (w_x[k+1]),
        .o_y    (w_y[k+1]),
        .o_z    (w_z[k+1])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dataa_d  = dataa_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dataa_d = dataa[30:0];
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        x_d     = K_INIT;
        y_d     = '0;
        z_d     = f2q(dataa_q);
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        x_d   = w_x[ROT_PER_CYC];
        y_d   = w_y[ROT_PER_CYC];
        z_d   = w_z[ROT_PER_CYC];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(ITER_CYC - 1)) begin
          result_d = w_x[ROT_PER_CYC];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // The pulse registers on the DONE->IDLE edge, after result is stable.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dataa_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dataa_q  <= dataa_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic.sv
`default_nettype none
// ============================================================================
// Module : tb_cordic
// Directed self-checking bench for cordic with a result scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_cordic;

  logic        clock = 1'b0;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  int    sb_exp [$];
  string sb_tag [$];
  int    mon_exp;
  string mon_tag;

  localparam int TOL = 16;

  cordic dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    checks++;
    assert ((d <= tol) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int cos_q22(input real ang);
    return $rtoi($cos(ang) * 4194304.0 + 0.5);
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending op.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_cnt++;
      check_eq("sb_pending", (sb_exp.size() != 0) ? 1 : 0, 1);
      if (sb_exp.size() != 0) begin
        mon_exp = sb_exp.pop_front();
        mon_tag = sb_tag.pop_front();
        check_near(mon_tag, $signed(result), mon_exp, TOL);
      end
    end
  end

  // Issue one operation, optionally stalling clk_en, and measure raw latency.
  task automatic run_op(input string tag, input logic [31:0] bits, input real ang,
                        input int stall_at, input int stall_len);
    int n;
    bit seen;
    @(negedge clock);
    dataa = bits;
    start = 1'b1;
    sb_exp.push_back(cos_q22(ang));
    sb_tag.push_back(tag);
    @(posedge clock);
    #1 start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clock);
      n++;
      #1;
      if (stall_len > 0 && n == stall_at) clk_en = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) clk_en = 1'b1;
      if (done === 1'b1) seen = 1'b1;
    end
    clk_en = 1'b1;
    check_eq({tag, "_latency"}, n, 6 + stall_len);
    @(posedge clock);
    #1 check_eq({tag, "_pulse_end"}, int'(done), 0);
  endtask

  initial begin
    int dc0;
    aclr   = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_result", int'(result), 0);
    check_eq("reset_done", int'(done), 0);
    clk_en = 1'b1;
    @(posedge clock);
    #1 aclr = 1'b0;

    run_op("cos_0p0",  32'h00000000,  0.0, 0, 0);
    run_op("cos_0p5",  32'h3F000000,  0.5, 0, 0);
    run_op("cos_0p9",  32'h3F666666,  0.9, 0, 0);
    run_op("cos_1p0",  32'h3F800000,  1.0, 0, 0);
    run_op("cos_m0p5", 32'hBF000000, -0.5, 0, 0);
    repeat (5) @(posedge clock);
    #1 check_near("result_hold", $signed(result), cos_q22(0.5), TOL);
    run_op("cos_denorm", 32'h00000001, 0.0, 0, 0);

    // Three disabled edges starting inside the ITER window.
    run_op("stall_0p9", 32'h3F666666, 0.9, 2, 3);

    // A start mid-ITER and another in the DONE cycle must both be ignored.
    dc0 = done_cnt;
    @(negedge clock);
    dataa = 32'h3F000000;
    start = 1'b1;
    sb_exp.push_back(cos_q22(0.5));
    sb_tag.push_back("busy_0p5");
    @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1 begin start = 1'b1; dataa = 32'h3F800000; end
    @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check_eq("busy_done_at_6", int'(done), 1);
    repeat (12) @(posedge clock);
    #1 check_eq("busy_single_done", done_cnt - dc0, 1);

    // Reset mid-ITER, with start raised alongside reset.
    dc0 = done_cnt;
    @(negedge clock);
    dataa = 32'h3F800000;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1 begin aclr = 1'b1; start = 1'b1; end
    @(posedge clock);
    #1 begin aclr = 1'b0; start = 1'b0; end
    check_eq("abort_result", int'(result), 0);
    check_eq("abort_done", int'(done), 0);
    repeat (12) @(posedge clock);
    #1 check_eq("abort_no_done", done_cnt - dc0, 0);

    run_op("after_rst_1p0", 32'h3F800000, 1.0, 0, 0);
`ifdef CORDIC_CLAMP_EN
    run_op("clamp_2p0", 32'h40000000, 1.0, 0, 0);
`endif

    repeat (3) @(posedge clock);
    #1 check_eq("sb_drained", sb_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
